// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
package pipe_pkg;

    // Widest register address the scoreboard can hold; narrower REG_AW values are zero-extended.
    localparam int RD_MAX_W = 8;

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic [RD_MAX_W-1:0] rd;
        logic                is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{
        valid:     1'b0,
        reg_write: 1'b0,
        rd:        8'd0,
        is_load:   1'b0
    };

    localparam int FWD_RF = 0;

    function automatic int fwd_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Youngest-producer search over the scoreboard for one source operand.
module fwd_match
    import pipe_pkg::*;
#(
    parameter  int DEPTH      = 3,
    parameter  int LOAD_READY = 2,
    parameter  int REG_AW     = 5,
    localparam int SEL_W      = fwd_width(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] sb,
    input  logic [REG_AW-1:0]     src,
    input  logic                  use_src,
    output logic [SEL_W-1:0]      match_idx,
    output logic                  hit,
    output logic                  load_not_ready
);

    logic [RD_MAX_W-1:0] src_ext_s;
    logic [DEPTH-1:0]    match_s;
    logic [DEPTH-1:0]    not_ready_s;

    assign src_ext_s = RD_MAX_W'(src);

    // Per-stage match and load readiness; LOAD_READY is counted in fwd-select numbering (stage index + 1).
    always_comb begin
        match_s     = {DEPTH{1'b0}};
        not_ready_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = use_src && sb[i].valid && sb[i].reg_write &&
                         (sb[i].rd != {RD_MAX_W{1'b0}}) && (sb[i].rd == src_ext_s);
            not_ready_s[i] = sb[i].is_load && ((i + 1) < LOAD_READY);
        end
    end

    // Priority select scanning oldest to youngest so the youngest producer overrides.
    always_comb begin
        hit            = 1'b0;
        match_idx      = {SEL_W{1'b0}};
        load_not_ready = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hit            = match_s[i] ? 1'b1 : hit;
            match_idx      = match_s[i] ? SEL_W'(i) : match_idx;
            load_not_ready = match_s[i] ? not_ready_s[i] : load_not_ready;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush controller sitting beside the ID stage.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter  int REG_AW     = 5,
    parameter  int DEPTH      = 3,
    parameter  int LOAD_READY = 2,
    parameter  int CNT_W      = 16,
    localparam int SEL_W      = fwd_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1'b1);
    localparam logic [SEL_W-1:0] SEL_RF    = SEL_W'(FWD_RF);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    sb_entry_t [DEPTH-1:0] sb_r;
    sb_entry_t             id_entry_s;
    logic [SEL_W-1:0]      a_idx_s;
    logic [SEL_W-1:0]      b_idx_s;
    logic                  a_hit_s;
    logic                  b_hit_s;
    logic                  a_not_ready_s;
    logic                  b_not_ready_s;
    logic                  load_use_s;
    logic                  stall_s;
    logic [CNT_W-1:0]      stall_cnt_r;
    logic [CNT_W-1:0]      flush_cnt_r;

    fwd_match #(
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY),
        .REG_AW     (REG_AW)
    ) u_match_a (
        .sb             (sb_r),
        .src            (id_rs),
        .use_src        (id_use_rs),
        .match_idx      (a_idx_s),
        .hit            (a_hit_s),
        .load_not_ready (a_not_ready_s)
    );

    fwd_match #(
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY),
        .REG_AW     (REG_AW)
    ) u_match_b (
        .sb             (sb_r),
        .src            (id_rt),
        .use_src        (id_use_rt),
        .match_idx      (b_idx_s),
        .hit            (b_hit_s),
        .load_not_ready (b_not_ready_s)
    );

    // Hazard decision; a taken branch squashes the dependent instruction, so it never stalls.
    always_comb begin
        id_entry_s           = SB_BUBBLE;
        id_entry_s.valid     = id_valid;
        id_entry_s.reg_write = id_reg_write;
        id_entry_s.rd        = RD_MAX_W'(id_rd);
        id_entry_s.is_load   = id_mem_read;
        load_use_s           = id_valid && ((a_hit_s && a_not_ready_s) || (b_hit_s && b_not_ready_s));
        stall_s              = load_use_s && !ex_branch_taken;
    end

    // Output drive: flush wins over stall, operand selects are 1-based stage codes.
    always_comb begin
        stall        = stall_s;
        if_id_flush  = ex_branch_taken;
        id_ex_bubble = stall_s || ex_branch_taken;
        fwd_a        = a_hit_s ? (a_idx_s + SEL_ONE) : SEL_RF;
        fwd_b        = b_hit_s ? (b_idx_s + SEL_ONE) : SEL_RF;
        stall_count  = stall_cnt_r;
        flush_count  = flush_cnt_r;
    end

    // Scoreboard shift: new entry into EX (bubble on stall/flush), oldest entry drops out of WB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_r <= {DEPTH{SB_BUBBLE}};
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sb_r[i] <= sb_r[i-1];
            end
            if (stall_s || ex_branch_taken) begin
                sb_r[0] <= SB_BUBBLE;
            end else begin
                sb_r[0] <= id_entry_s;
            end
        end
    end

    // Saturating event counters; a flush cycle never carries a stall, so no double count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt_r != CNT_SAT)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (ex_branch_taken && (flush_cnt_r != CNT_SAT)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench: default unit, a narrow-counter unit and a deep-pipeline unit share one ID stream.
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, ex_branch_taken;
    logic [4:0] id_rs, id_rt, id_rd;

    logic        s0, fl0, bb0;
    logic [1:0]  fa0, fb0;
    logic [15:0] sc0, fc0;
    logic        s1, fl1, bb1;
    logic [1:0]  fa1, fb1;
    logic [3:0]  sc1, fc1;
    logic        s2, fl2, bb2;
    logic [2:0]  fa2, fb2;
    logic [15:0] sc2, fc2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit u_dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write), .id_rd(id_rd),
        .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken), .stall(s0), .if_id_flush(fl0),
        .id_ex_bubble(bb0), .fwd_a(fa0), .fwd_b(fb0), .stall_count(sc0), .flush_count(fc0)
    );

    pipe_hazard_unit #(.CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write), .id_rd(id_rd),
        .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken), .stall(s1), .if_id_flush(fl1),
        .id_ex_bubble(bb1), .fwd_a(fa1), .fwd_b(fb1), .stall_count(sc1), .flush_count(fc1)
    );

    pipe_hazard_unit #(.DEPTH(5), .LOAD_READY(3)) u_dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write), .id_rd(id_rd),
        .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken), .stall(s2), .if_id_flush(fl2),
        .id_ex_bubble(bb2), .fwd_a(fa2), .fwd_b(fb2), .stall_count(sc2), .flush_count(fc2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic st, input logic fl, input logic bb,
                        input logic [1:0] fa, input logic [1:0] fb);
        check_val({tag, "_stall"},  32'(s0),  32'(st));
        check_val({tag, "_flush"},  32'(fl0), 32'(fl));
        check_val({tag, "_bubble"}, 32'(bb0), 32'(bb));
        check_val({tag, "_fwd_a"},  32'(fa0), 32'(fa));
        check_val({tag, "_fwd_b"},  32'(fb0), 32'(fb));
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic rw,
                          input logic [4:0] rd, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_reg_write = rw; id_rd = rd; id_mem_read = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        reset = 1'b0;
        ex_branch_taken = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #2;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        ex_branch_taken = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #12;
        chk0("rst", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        check_val("rst_sc0", 32'(sc0), 32'd0);
        check_val("rst_fc0", 32'(fc0), 32'd0);
        check_val("rst_sc1", 32'(sc1), 32'd0);
        check_val("rst_s2",  32'(s2),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // ALU-to-ALU: add r1,r2,r3 ; sub r4,r1,r5 ; or r6,r1,r7
        set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0); #1;
        chk0("alu_add", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0); tick();
        set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); #1;
        chk0("alu_sub", 1'b0, 1'b0, 1'b0, 2'd1, 2'd0); tick();
        set_id(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0); #1;
        chk0("alu_or", 1'b0, 1'b0, 1'b0, 2'd2, 2'd0); tick();

        // Load-use: lw r1 ; add r2,r1,r1 (held one cycle) ; then a gap case
        hard_reset();
        set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1); #1;
        chk0("lw", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0); tick();
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0); #1;
        chk0("lu_stall", 1'b1, 1'b0, 1'b1, 2'd1, 2'd1);
        check_val("lu_sc_before", 32'(sc0), 32'd0); tick();
        chk0("lu_after", 1'b0, 1'b0, 1'b0, 2'd2, 2'd2);
        check_val("lu_sc_after", 32'(sc0), 32'd1); tick();
        set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1); #1;
        chk0("lw_r3", 1'b0, 1'b0, 1'b0, 2'd1, 2'd0); tick();
        set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0); #1;
        chk0("indep", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0); tick();
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0); #1;
        chk0("lu_gap", 1'b0, 1'b0, 1'b0, 2'd2, 2'd2);
        check_val("lu_gap_sc", 32'(sc0), 32'd1); tick();

        // r0 never forwards; two writers of r7 -> youngest wins; use flags gate matching
        hard_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0); #1; tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0); #1;
        chk0("r0", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0); tick();
        set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0); #1;
        chk0("r7_one", 1'b0, 1'b0, 1'b0, 2'd1, 2'd0); tick();
        set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0); #1;
        chk0("r7_young", 1'b0, 1'b0, 1'b0, 2'd1, 2'd1); tick();
        set_id(1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0); #1;
        chk0("no_use", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0); tick();

        // Branch taken while ID holds a load-dependent instruction
        hard_reset();
        set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1); #1; tick();
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);
        ex_branch_taken = 1'b1; #1;
        chk0("br", 1'b0, 1'b1, 1'b1, 2'd1, 2'd1); tick();
        ex_branch_taken = 1'b0; #1;
        chk0("br_after", 1'b0, 1'b0, 1'b0, 2'd2, 2'd2);
        check_val("br_fc", 32'(fc0), 32'd1);
        check_val("br_sc", 32'(sc0), 32'd0);

        // Drain, build up counts, then reset while stalled
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1); tick();
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0); tick();
        tick();
        set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1); tick();
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); #1;
        chk0("pre_rst", 1'b1, 1'b0, 1'b1, 2'd1, 2'd1);
        check_val("pre_rst_sc", 32'(sc0), 32'd1);
        check_val("pre_rst_fc", 32'(fc0), 32'd1);
        #1;
        reset = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
        chk0("rst_mid", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        check_val("rst_mid_sc", 32'(sc0), 32'd0);
        check_val("rst_mid_fc", 32'(fc0), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); #1;
        chk0("post_rst", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0); tick();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); tick();

        // Twenty load-use stalls: 16-bit counter reaches 20, 4-bit counter saturates at 15
        for (int n = 0; n < 20; n++) begin
            set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1); tick();
            set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); tick();
            tick();
        end
        check_val("sat_sc0", 32'(sc0), 32'd20);
        check_val("sat_sc1", 32'(sc1), 32'd15);

        // Deep pipeline, load data ready from fwd code 3: two stall cycles
        hard_reset();
        set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1); tick();
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0); #1;
        check_val("deep_s_c0", 32'(s2), 32'd1);
        check_val("deep_fa_c0", 32'(fa2), 32'd1); tick();
        check_val("deep_s_c1", 32'(s2), 32'd1);
        check_val("deep_fa_c1", 32'(fa2), 32'd2); tick();
        check_val("deep_s_c2", 32'(s2), 32'd0);
        check_val("deep_fa_c2", 32'(fa2), 32'd3);
        check_val("deep_fb_c2", 32'(fb2), 32'd3);
        check_val("deep_sc", 32'(sc2), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
